// File: rtl/ifu_top.sv
// Instruction fetch unit: holds the architectural PC, fetches one word at a time
// and hands it to the decoder, advancing only after the CU retires the instruction.
module ifu_top #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        soc_clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  output logic [31:0] instruction,
  output logic        Fetch_ready,
  input  logic        IDU_ready,
  input  logic [31:0] pc_increment,
  input  logic        cu_done,
  input  logic        cu_redirect,
  input  logic [31:0] cu_target,
  output logic [31:0] fetch_pc,
  output logic        fetch_fault,
  output logic [1:0]  fault_code
);

  // state      | meaning
  // FETCH_REQ  | waiting for stall to clear, then strobe a request at pc
  // FETCH_WAIT | request issued, counting cycles until imem_valid or timeout
  // DELIVER    | word held for the decoder until IDU_ready
  // EXEC       | waiting for the CU to retire; computes and checks next pc
  // FAULT      | absorbing until reset; fault_code holds the cause
  typedef enum logic [2:0] {
    FETCH_REQ,
    FETCH_WAIT,
    DELIVER,
    EXEC,
    FAULT
  } state_t;

  localparam logic [31:0] NOP_INSN    = 32'h0000_0013;
  localparam logic [7:0]  TIMEOUT_LIM = 8'(MEM_TIMEOUT);
  localparam logic [1:0]  CODE_NONE   = 2'b00;
  localparam logic [1:0]  CODE_ALIGN  = 2'b01;
  localparam logic [1:0]  CODE_TMO    = 2'b10;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] instr_q, instr_d;
  logic        req_q, req_d;
  logic        ready_q, ready_d;
  logic        fault_q, fault_d;
  logic [1:0]  code_q, code_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] next_pc;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    req_d      = 1'b0;
    ready_d    = ready_q;
    fault_d    = fault_q;
    code_d     = code_q;
    cnt_d      = cnt_q;
    next_pc    = cu_redirect ? cu_target : pc_q + pc_increment;

    case (state_q)
      FETCH_REQ: begin
        if (!stall) begin
          req_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // A word arriving on the timeout cycle is still taken.
        if (imem_valid) begin
          instr_d    = imem_rdata;
          fetch_pc_d = pc_q;
          ready_d    = 1'b1;
          state_d    = DELIVER;
        end else if (cnt_q + 8'd1 == TIMEOUT_LIM) begin
          fault_d = 1'b1;
          code_d  = CODE_TMO;
          state_d = FAULT;
        end
      end
      DELIVER: begin
        if (IDU_ready) begin
          ready_d = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cu_done) begin
          if (next_pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            code_d  = CODE_ALIGN;
            state_d = FAULT;
          end else begin
            pc_d    = next_pc;
            state_d = FETCH_REQ;
          end
        end
      end
      FAULT: begin
        ready_d = 1'b0;
      end
      default: begin
        state_d = FETCH_REQ;
      end
    endcase
  end

  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FETCH_REQ;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      instr_q    <= NOP_INSN;
      req_q      <= 1'b0;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
      code_q     <= CODE_NONE;
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      req_q      <= req_d;
      ready_q    <= ready_d;
      fault_q    <= fault_d;
      code_q     <= code_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign Fetch_ready = ready_q;
  assign fetch_pc    = fetch_pc_q;
  assign fetch_fault = fault_q;
  assign fault_code  = code_q;

endmodule

// File: tb/tb_ifu_top.sv
// Directed bench for ifu_top: handshake, PC stepping/wrap, redirect, timeout,
// stall hold and asynchronous reset from DELIVER and FAULT.
module tb_ifu_top;

  logic        soc_clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic [31:0] instruction;
  logic        Fetch_ready;
  logic        IDU_ready;
  logic [31:0] pc_increment;
  logic        cu_done;
  logic        cu_redirect;
  logic [31:0] cu_target;
  logic [31:0] fetch_pc;
  logic        fetch_fault;
  logic [1:0]  fault_code;

  int tests_run    = 0;
  int tests_failed = 0;

  ifu_top #(.RESET_PC(32'h0000_0000), .MEM_TIMEOUT(8)) dut (
    .soc_clk      (soc_clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_valid   (imem_valid),
    .stall        (stall),
    .instruction  (instruction),
    .Fetch_ready  (Fetch_ready),
    .IDU_ready    (IDU_ready),
    .pc_increment (pc_increment),
    .cu_done      (cu_done),
    .cu_redirect  (cu_redirect),
    .cu_target    (cu_target),
    .fetch_pc     (fetch_pc),
    .fetch_fault  (fetch_fault),
    .fault_code   (fault_code)
  );

  initial soc_clk = 1'b0;
  always #5 soc_clk = ~soc_clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge soc_clk);
    #1;
  endtask

  // Reset-value vector: {imem_req, imem_addr, instruction, Fetch_ready, fetch_pc, fetch_fault, fault_code}
  function automatic logic [100:0] out_vec();
    return {imem_req, imem_addr, instruction, Fetch_ready, fetch_pc, fetch_fault, fault_code};
  endfunction

  localparam logic [100:0] RESET_VEC = {1'b0, 32'h0, 32'h0000_0013, 1'b0, 32'h0, 1'b0, 2'b00};

  task automatic cu_pulse(input logic redir, input logic [31:0] tgt, input logic [31:0] inc);
    cu_done = 1'b1; cu_redirect = redir; cu_target = tgt; pc_increment = inc;
    tick();
    cu_done = 1'b0; cu_redirect = 1'b0;
  endtask

  // From FETCH_REQ: request, zero-wait response, decoder accept; ends in EXEC.
  task automatic fetch_word(input string tag, input logic [31:0] word, input logic [31:0] exp_addr);
    tick();
    tests_run++;
    if ({imem_req, imem_addr} !== {1'b1, exp_addr}) begin
      tests_failed++;
      $display("FAIL %s_req: req=%b addr=%h, want req=1 addr=%h", tag, imem_req, imem_addr, exp_addr);
    end
    imem_valid = 1'b1; imem_rdata = word;
    tick();
    imem_valid = 1'b0;
    tests_run++;
    if ({Fetch_ready, instruction, fetch_pc} !== {1'b1, word, exp_addr}) begin
      tests_failed++;
      $display("FAIL %s_deliver: rdy=%b insn=%h fpc=%h, want rdy=1 insn=%h fpc=%h",
               tag, Fetch_ready, instruction, fetch_pc, word, exp_addr);
    end
    IDU_ready = 1'b1;
    tick();
    IDU_ready = 1'b0;
  endtask

  task automatic async_reset_check(input string tag);
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (out_vec() !== RESET_VEC) begin
      tests_failed++;
      $display("FAIL %s_async_reset: got %h want %h", tag, out_vec(), RESET_VEC);
    end
    @(posedge soc_clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    tests_run++;
    if (out_vec() !== RESET_VEC) begin
      tests_failed++;
      $display("FAIL reset_values: got %h want %h", out_vec(), RESET_VEC);
    end
    reset = 1'b1;
    tick();
    tests_run++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      tests_failed++;
      $display("FAIL first_req: req=%b addr=%h, want 1/00000000", imem_req, imem_addr);
    end
    tick();
    tests_run++;
    if ({imem_req, Fetch_ready} !== 2'b00) begin
      tests_failed++;
      $display("FAIL req_one_cycle: req=%b rdy=%b, want 0/0", imem_req, Fetch_ready);
    end
    imem_valid = 1'b1; imem_rdata = 32'h0050_0093;
    tick();
    imem_valid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    tests_run++;
    if ({Fetch_ready, instruction, fetch_pc} !== {1'b1, 32'h0050_0093, 32'h0}) begin
      tests_failed++;
      $display("FAIL first_deliver: rdy=%b insn=%h fpc=%h, want 1/00500093/00000000",
               Fetch_ready, instruction, fetch_pc);
    end
    // cu_done and a stray imem_valid during DELIVER must be ignored.
    cu_done = 1'b1; cu_redirect = 1'b1; cu_target = 32'h80; imem_valid = 1'b1;
    tick();
    cu_done = 1'b0; cu_redirect = 1'b0; imem_valid = 1'b0;
    tick();
    tests_run++;
    if ({Fetch_ready, instruction, imem_addr} !== {1'b1, 32'h0050_0093, 32'h0}) begin
      tests_failed++;
      $display("FAIL deliver_hold: rdy=%b insn=%h addr=%h, want 1/00500093/00000000",
               Fetch_ready, instruction, imem_addr);
    end
    IDU_ready = 1'b1;
    tick();
    IDU_ready = 1'b0;
    tests_run++;
    if (Fetch_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL ready_drop: rdy=%b want 0", Fetch_ready);
    end
  endtask

  task automatic test_wrap();
    cu_pulse(1'b1, 32'h0000_0FFC, 32'h0);
    fetch_word("wrap_ffc", 32'h1111_1111, 32'h0000_0FFC);
    cu_pulse(1'b0, 32'h0, 32'h4);
    tests_run++;
    if (imem_addr !== 32'h0000_1000) begin
      tests_failed++;
      $display("FAIL step_1000: addr=%h want 00001000", imem_addr);
    end
    fetch_word("wrap_1000", 32'h2222_2222, 32'h0000_1000);
    cu_pulse(1'b1, 32'hFFFF_FFFC, 32'h0);
    fetch_word("wrap_top", 32'h3333_3333, 32'hFFFF_FFFC);
    cu_pulse(1'b0, 32'h0, 32'h4);
    tests_run++;
    if (imem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_zero: addr=%h want 00000000", imem_addr);
    end
    fetch_word("wrap_zero", 32'h4444_4444, 32'h0);
  endtask

  task automatic test_stall();
    stall = 1'b1;
    cu_pulse(1'b0, 32'h0, 32'h8);
    tests_run++;
    if ({imem_req, imem_addr} !== {1'b0, 32'h8}) begin
      tests_failed++;
      $display("FAIL stall_pc_update: req=%b addr=%h, want 0/00000008", imem_req, imem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (imem_req !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_no_req[%0d]: req=%b want 0", i, imem_req);
      end
    end
    stall = 1'b0;
    tick();
    tests_run++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
      tests_failed++;
      $display("FAIL stall_release_req: req=%b addr=%h, want 1/00000008", imem_req, imem_addr);
    end
    imem_valid = 1'b1; imem_rdata = 32'h5555_5554;
    tick();
    imem_valid = 1'b0;
    IDU_ready = 1'b1;
    tick();
    IDU_ready = 1'b0;
  endtask

  task automatic test_redirect();
    cu_pulse(1'b1, 32'h0000_0200, 32'h4);
    fetch_word("redir_200", 32'h6666_6666, 32'h0000_0200);
    cu_pulse(1'b1, 32'h0000_0202, 32'h4);
    tests_run++;
    if ({fetch_fault, fault_code, imem_addr} !== {1'b1, 2'b01, 32'h200}) begin
      tests_failed++;
      $display("FAIL misalign_fault: flt=%b code=%b addr=%h, want 1/01/00000200",
               fetch_fault, fault_code, imem_addr);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if ({imem_req, Fetch_ready, fetch_fault, fault_code} !== {1'b0, 1'b0, 1'b1, 2'b01}) begin
        tests_failed++;
        $display("FAIL fault_absorb[%0d]: req=%b rdy=%b flt=%b code=%b, want 0/0/1/01",
                 i, imem_req, Fetch_ready, fetch_fault, fault_code);
      end
    end
    async_reset_check("fault");
  endtask

  task automatic test_timeout();
    tick();
    repeat (7) tick();
    tests_run++;
    if (fetch_fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_early: flt=%b want 0 after 7 wait cycles", fetch_fault);
    end
    tick();
    tests_run++;
    if ({fetch_fault, fault_code} !== {1'b1, 2'b10}) begin
      tests_failed++;
      $display("FAIL timeout_fault: flt=%b code=%b, want 1/10", fetch_fault, fault_code);
    end
    @(posedge soc_clk);
    #1 reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    repeat (7) tick();
    imem_valid = 1'b1; imem_rdata = 32'h7777_7777;
    tick();
    imem_valid = 1'b0;
    tests_run++;
    if ({Fetch_ready, instruction, fetch_fault, fault_code} !== {1'b1, 32'h7777_7777, 1'b0, 2'b00}) begin
      tests_failed++;
      $display("FAIL timeout_last_cycle_accept: rdy=%b insn=%h flt=%b code=%b, want 1/77777777/0/00",
               Fetch_ready, instruction, fetch_fault, fault_code);
    end
    IDU_ready = 1'b1;
    tick();
    IDU_ready = 1'b0;
  endtask

  task automatic test_reset_deliver();
    cu_pulse(1'b1, 32'h0000_0040, 32'h0);
    tick();
    imem_valid = 1'b1; imem_rdata = 32'h8888_8888;
    tick();
    imem_valid = 1'b0;
    tests_run++;
    if ({Fetch_ready, fetch_pc} !== {1'b1, 32'h40}) begin
      tests_failed++;
      $display("FAIL deliver_40: rdy=%b fpc=%h, want 1/00000040", Fetch_ready, fetch_pc);
    end
    async_reset_check("deliver");
    fetch_word("restart", 32'h9999_9998, 32'h0);
  endtask

  initial begin
    reset = 1'b0; imem_rdata = 32'h0; imem_valid = 1'b0; stall = 1'b0;
    IDU_ready = 1'b0; pc_increment = 32'h0; cu_done = 1'b0; cu_redirect = 1'b0;
    cu_target = 32'h0;
    test_reset();
    test_wrap();
    test_stall();
    test_redirect();
    test_timeout();
    test_reset_deliver();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ifu_top.md
Name: ifu_top

Overview:
Instruction fetch unit feeding IDU_top. Holds the architectural PC and issues one word fetch to instruction memory. Presents the returned word to the decoder through the Fetch_ready/IDU_ready handshake, then waits for the CU to finish the instruction before advancing the PC. The PC advances by the decoder's pc_increment, or to a CU redirect target. One instruction is in flight at a time; there is no prefetch.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
MEM_TIMEOUT, 255, maximum cycles spent in FETCH_WAIT before a bus fault (legal range 1..255).

Ports:
soc_clk  input  1  system clock; all state updates on posedge.
reset  input  1  asynchronous, active-low reset.
imem_req  output  1  single-cycle fetch request strobe.
imem_addr  output  32  fetch address; equals pc.
imem_rdata  input  32  fetched instruction word.
imem_valid  input  1  imem_rdata valid this cycle.
stall  input  1  CU hold; while high, no new request is issued.
instruction  output  32  registered instruction to IDU.
Fetch_ready  output  1  instruction valid to IDU (level signal).
IDU_ready  input  1  decoder has accepted and decoded the instruction.
pc_increment  input  32  PC step from IDU, sampled at cu_done.
cu_done  input  1  one-cycle pulse; CU retired the current instruction.
cu_redirect  input  1  qualifies cu_done; next PC is cu_target.
cu_target  input  32  redirect target (branch, JAL, JALR).
fetch_pc  output  32  PC of the word currently in instruction.
fetch_fault  output  1  sticky fault flag.
fault_code  output  2  00 none, 01 misaligned target, 10 memory timeout.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- While reset is low:
  - state = FETCH_REQ, pc = RESET_PC, imem_addr = RESET_PC, fetch_pc = RESET_PC.
  - imem_req = 0, instruction = 32'h0000_0013 (NOP), Fetch_ready = 0.
  - fetch_fault = 0, fault_code = 00, timeout counter = 0.
- Reset mid-operation: the in-flight fetch is abandoned. Instruction memory must drop any outstanding response on the same reset.
- FSM states: FETCH_REQ, FETCH_WAIT, DELIVER, EXEC, FAULT.
- FETCH_REQ:
  - If stall = 1: stay, imem_req = 0.
  - Else: imem_req = 1 for exactly one cycle with imem_addr = pc; clear the counter; go to FETCH_WAIT.
- FETCH_WAIT:
  - Counter increments each cycle.
  - On imem_valid: instruction <= imem_rdata, fetch_pc <= pc, Fetch_ready <= 1, go to DELIVER.
  - If counter reaches MEM_TIMEOUT without imem_valid: go to FAULT with code 10.
  - imem_valid in the same cycle as the timeout wins (the word is accepted).
- imem_valid outside FETCH_WAIT is ignored.
- DELIVER:
  - Fetch_ready holds 1 and instruction holds stable until IDU_ready = 1 is sampled.
  - That cycle: Fetch_ready <= 0, go to EXEC.
  - Minimum Fetch_ready width is 1 cycle.
  - IDU_ready already high on entry completes the handshake on the first DELIVER cycle.
- EXEC:
  - Wait for cu_done. Then next = cu_redirect ? cu_target : pc + pc_increment.
  - The add is 32-bit and wraps modulo 2^32.
  - If next[1:0] != 00 (no compressed support): go to FAULT with code 01; pc is not updated.
  - Otherwise pc <= next and go to FETCH_REQ.
  - cu_done together with stall: the PC still updates; the request is held in FETCH_REQ.
- cu_done outside EXEC is ignored.
- FAULT:
  - Absorbing until reset; fetch_fault = 1 and fault_code holds.
  - imem_req = 0, Fetch_ready = 0.
- imem_addr always equals pc.
- Best-case latency: request to Fetch_ready is 2 cycles with a 1-cycle memory. Throughput is gated by the CU.

Test Plan:
- Reset release, memory returns 32'h00500093 one cycle after imem_req at addr 0 → Fetch_ready rises the next cycle with instruction = 32'h00500093 and fetch_pc = 0; it holds until IDU_ready, then drops one cycle later.
- cu_done with cu_redirect = 0 and pc_increment = 4 at pc 0x0000_0FFC, followed by a second step at pc 0xFFFF_FFFC → next fetch addr is 0x1000, then wraps to 0x0000_0000.
- cu_done with cu_redirect = 1 and cu_target = 0x0000_0200 → imem_addr = 0x200 on the next request; a target of 0x0000_0202 instead gives fetch_fault = 1, fault_code = 01, and no further imem_req.
- Memory never responds with MEM_TIMEOUT = 8 → fault_code = 10 exactly 8 cycles into FETCH_WAIT; imem_valid arriving on cycle 8 is accepted with no fault.
- stall held high for 5 cycles after cu_done → no imem_req for those cycles and pc already updated; a request is issued in the cycle after stall falls.
- reset pulled low while in DELIVER or FAULT → all outputs return to their reset values immediately (asynchronously), and fetch restarts at RESET_PC after release.
